// File: rtl/spi_cmd_arbiter_pkg.sv
// Shared definitions for the SPI command arbiter: frame layout, FSM encoding
// and the helper that picks the outgoing byte for a given frame position.
package spi_cmd_arbiter_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;
  localparam int         FRAME_BYTES       = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_DONE = 3'd2,
    ST_GAP  = 3'd3
  } state_e;

  // Frame order: header, address, then write data least-significant byte first.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [7:0]  sync,
                                            input logic [7:0]  addr,
                                            input logic [31:0] data);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = addr;
      3'd2:    b = data[7:0];
      3'd3:    b = data[15:8];
      3'd4:    b = data[23:16];
      default: b = data[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_cmd_arbiter_rr_arbiter.sv
// Round-robin picker: combinational search starting after the previous winner,
// with the previous winner held in a register updated when a grant is taken.
module spi_cmd_arbiter_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req_i,
  input  logic            take_i,
  output logic [2:0]      grant_idx_o,
  output logic            grant_vld_o
);

  logic [2:0] last_q, last_d;
  logic [7:0] req_pad;
  logic [3:0] cand;

  always_comb begin
    req_pad     = 8'(req_i);
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    cand        = '0;
    // The previous owner is visited last, so it only wins when nobody else asks.
    for (int off = 1; off <= NREQ; off++) begin
      cand = {1'b0, last_q} + 4'(off);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!grant_vld_o && req_pad[cand[2:0]]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = cand[2:0];
      end
    end
    last_d = take_i ? grant_idx_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) last_q <= 3'(NREQ - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Shares one SPI byte engine between NREQ requesters: round-robin grant, 6-byte
// framed command out, 32-bit response collected from MISO bytes 2..5.
module spi_cmd_arbiter
  import spi_cmd_arbiter_pkg::*;
#(
  parameter int         NREQ       = 2,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int         GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [32*NREQ-1:0] req_data,
  output logic              rsp_valid,
  output logic [2:0]        rsp_id,
  output logic [31:0]       rsp_data,
  output logic              busy,
  output logic              m_ready,
  output logic [7:0]        m_tx_data,
  input  logic              m_valid,
  input  logic [7:0]        m_rx_data
);

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [2:0]      gid_q, gid_d;
  logic [23:0]     rsp_buf_q, rsp_buf_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [2:0]      rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d;
  logic            m_ready_q, m_ready_d;
  logic [7:0]      m_tx_data_q, m_tx_data_d;
  logic            take;
  logic [2:0]      grant_idx;
  logic            grant_vld;

  spi_cmd_arbiter_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk         (clk),
    .rstn        (rstn),
    .req_i       (req_valid),
    .take_i      (take),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    gid_d       = gid_q;
    rsp_buf_d   = rsp_buf_q;
    req_ready_d = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    m_ready_d   = m_ready_q;
    m_tx_data_d = m_tx_data_q;
    take        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          take = 1'b1;
          for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == 3'(k)) begin
              req_ready_d[k] = 1'b1;
              addr_d         = req_addr[8*k +: 8];
              data_d         = req_data[32*k +: 32];
            end
          end
          gid_d       = grant_idx;
          busy_d      = 1'b1;
          idx_d       = '0;
          m_ready_d   = 1'b1;
          m_tx_data_d = SYNC_BYTE;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        // m_ready low marks the one-cycle spacer after each transfer.
        if (!m_ready_q) begin
          m_ready_d = 1'b1;
        end else if (m_valid) begin
          m_ready_d = 1'b0;
          case (idx_q)
            3'd2:    rsp_buf_d[7:0]   = m_rx_data;
            3'd3:    rsp_buf_d[15:8]  = m_rx_data;
            3'd4:    rsp_buf_d[23:16] = m_rx_data;
            default: ;
          endcase
          if (idx_q == 3'(FRAME_BYTES - 1)) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gid_q;
            rsp_data_d  = {m_rx_data, rsp_buf_q};
            state_d     = ST_DONE;
          end else begin
            idx_d       = idx_q + 3'd1;
            m_tx_data_d = frame_byte(idx_q + 3'd1, SYNC_BYTE, addr_q, data_q);
          end
        end
      end
      ST_DONE: begin
        if (GAP_CYCLES == 0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(GAP_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        idx_d       = '0;
        cnt_d       = '0;
        rsp_id_d    = '0;
        rsp_data_d  = '0;
        busy_d      = 1'b0;
        m_ready_d   = 1'b0;
        m_tx_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      m_ready_q   <= 1'b0;
      m_tx_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      m_ready_q   <= m_ready_d;
      m_tx_data_q <= m_tx_data_d;
    end
  end

  // Command payload and partial response are only meaningful inside a frame.
  always_ff @(posedge clk) begin
    addr_q    <= addr_d;
    data_q    <= data_d;
    gid_q     <= gid_d;
    rsp_buf_q <= rsp_buf_d;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign m_ready   = m_ready_q;
  assign m_tx_data = m_tx_data_q;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter with a behavioural spi_master model:
// one instance with a 4-cycle gap and one with no gap.
module tb_spi_cmd_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [1:0]  rv0, rr0, rv1, rr1;
  logic [15:0] ra0, ra1;
  logic [63:0] rd0, rd1;
  logic        rsv0, rsv1, busy0, busy1, mr0, mr1, mv0, mv1;
  logic [2:0]  rid0, rid1;
  logic [31:0] rdat0, rdat1;
  logic [7:0]  mtx0, mtx1, mrx0, mrx1;
  logic [1:0]  mv_m = '0;
  logic [1:0]  inj  = '0;

  assign mv0 = mv_m[0] | inj[0];
  assign mv1 = mv_m[1] | inj[1];

  spi_cmd_arbiter #(.NREQ(2), .SYNC_BYTE(8'h5A), .GAP_CYCLES(4)) u_dut0 (
    .clk(clk), .rstn(rstn), .req_valid(rv0), .req_ready(rr0), .req_addr(ra0),
    .req_data(rd0), .rsp_valid(rsv0), .rsp_id(rid0), .rsp_data(rdat0), .busy(busy0),
    .m_ready(mr0), .m_tx_data(mtx0), .m_valid(mv0), .m_rx_data(mrx0));

  spi_cmd_arbiter #(.NREQ(2), .SYNC_BYTE(8'h5A), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .rstn(rstn), .req_valid(rv1), .req_ready(rr1), .req_addr(ra1),
    .req_data(rd1), .rsp_valid(rsv1), .rsp_id(rid1), .rsp_data(rdat1), .busy(busy1),
    .m_ready(mr1), .m_tx_data(mtx1), .m_valid(mv1), .m_rx_data(mrx1));

  // spi_master model: m_valid 8 cycles after m_ready rises, MISO = 0xA0 + byte index.
  int         cnt_m [2];
  int         byte_n[2];
  logic       prev_rdy[2];
  logic [7:0] hold_m[2];
  logic [7:0] rx_m  [2];
  logic [7:0] tx_log[$];

  assign mrx0 = rx_m[0];
  assign mrx1 = rx_m[1];

  always @(negedge clk) begin : model
    logic [1:0] rdy, rr_any;
    logic [7:0] tx [2];
    rdy    = {mr1, mr0};
    rr_any = {|rr1, |rr0};
    tx[0]  = mtx0;
    tx[1]  = mtx1;
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        mv_m[k] = 1'b0; cnt_m[k] = 0; byte_n[k] = 0; prev_rdy[k] = 1'b0;
      end else begin
        if (rr_any[k]) byte_n[k] = 0;
        if (mv_m[k]) begin
          mv_m[k] = 1'b0;
          if (k == 0) tx_log.push_back(hold_m[k]);
          byte_n[k] = (byte_n[k] == 5) ? 0 : byte_n[k] + 1;
        end
        if (rdy[k]) begin
          cnt_m[k] = prev_rdy[k] ? cnt_m[k] + 1 : 0;
          if (cnt_m[k] == 8) begin
            mv_m[k]   = 1'b1;
            rx_m[k]   = 8'hA0 + 8'(byte_n[k]);
            hold_m[k] = tx[k];
          end
        end
        prev_rdy[k] = rdy[k];
      end
    end
  end

  typedef struct {
    logic [1:0]  rv;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic [7:0]  a1;
    logic [31:0] d1;
    logic [1:0]  exp_rr;
    logic [2:0]  exp_id;
    logic [47:0] exp_bytes;
  } vec_t;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle0(input string name);
    int n = 0;
    while (busy0 && n < 300) begin tick(); n++; end
    chk(name, busy0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0; rv0 = '0; rv1 = '0; inj = '0;
    repeat (3) tick();
    chk({tag, ".req_ready"}, rr0, 2'b00);
    chk({tag, ".rsp_valid"}, rsv0, 1'b0);
    chk({tag, ".rsp_id"}, rid0, 3'd0);
    chk({tag, ".rsp_data"}, rdat0, 32'h0);
    chk({tag, ".busy"}, busy0, 1'b0);
    chk({tag, ".m_ready"}, mr0, 1'b0);
    chk({tag, ".m_tx_data"}, mtx0, 8'h00);
    chk({tag, ".busy1"}, busy1, 1'b0);
    rstn = 1'b1;
    tick();
    tx_log.delete();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [47:0] got;
    int n;
    tick();
    rv0 = v.rv; ra0 = {v.a1, v.a0}; rd0 = {v.d1, v.d0};
    tick();
    chk({tag, ".ready"}, rr0, v.exp_rr);
    chk({tag, ".busy"}, busy0, 1'b1);
    rv0 = '0;
    tick();
    chk({tag, ".ready_pulse"}, rr0, 2'b00);
    n = 0;
    while (!rsv0 && n < 200) begin tick(); n++; end
    chk({tag, ".rsp_seen"}, rsv0, 1'b1);
    chk({tag, ".rsp_id"}, rid0, v.exp_id);
    chk({tag, ".rsp_data"}, rdat0, 32'hA5A4A3A2);
    chk({tag, ".nbytes"}, tx_log.size(), 6);
    got = '0;
    for (int i = 0; i < 6; i++)
      if (tx_log.size() != 0) got = {got[39:0], tx_log.pop_front()};
    chk({tag, ".bytes"}, got, v.exp_bytes);
    tick();
    chk({tag, ".rsp_pulse"}, rsv0, 1'b0);
    wait_idle0({tag, ".idle"});
    tx_log.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vec[6];
    vec_t vr;
    int   n, nord, k, zeros, saw;
    int   ord[4];
    logic [47:0] got;

    // Grant expectations assume last_grant=1 after reset.
    vec[0] = '{2'b01, 8'h02, 32'h11223344, 8'h00, 32'h00000000, 2'b01, 3'd0, 48'h5A0244332211};
    vec[1] = '{2'b10, 8'h00, 32'h00000000, 8'h80, 32'hDEADBEEF, 2'b10, 3'd1, 48'h5A80EFBEADDE};
    vec[2] = '{2'b11, 8'h10, 32'h01020304, 8'h20, 32'hA1B2C3D4, 2'b01, 3'd0, 48'h5A1004030201};
    vec[3] = '{2'b11, 8'h10, 32'h01020304, 8'h20, 32'hA1B2C3D4, 2'b10, 3'd1, 48'h5A20D4C3B2A1};
    vec[4] = '{2'b10, 8'h00, 32'h00000000, 8'h7F, 32'h00FF00FF, 2'b10, 3'd1, 48'h5A7FFF00FF00};
    vec[5] = '{2'b01, 8'hC3, 32'h80000001, 8'h00, 32'h00000000, 2'b01, 3'd0, 48'h5AC301000080};
    ra0 = '0; rd0 = '0; ra1 = '0; rd1 = '0;

    do_reset("rst");
    for (int i = 0; i < 6; i++) run_vec(vec[i], $sformatf("vec%0d", i));

    // Both requesters held continuously after reset: 0,1,0,1.
    do_reset("rst2");
    rv0 = 2'b11; ra0 = {8'h22, 8'h11}; rd0 = {32'h0, 32'h0};
    nord = 0; n = 0;
    for (int i = 0; i < 4; i++) ord[i] = -1;
    while (nord < 4 && n < 3000) begin
      tick(); n++;
      if (rr0 != 2'b00) begin
        ord[nord] = (rr0 == 2'b10) ? 1 : 0;
        nord++;
        if (nord == 4) rv0 = '0;
      end
    end
    chk("rr.count", nord, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr.order%0d", i), ord[i], i % 2);
    wait_idle0("rr.idle");
    tx_log.delete();

    // Request raised mid-frame waits out the gap.
    rv0 = 2'b01; ra0 = {8'h66, 8'h55}; rd0 = {32'h0, 32'h12345678};
    tick();
    chk("mid.ready0", rr0, 2'b01);
    rv0 = '0;
    repeat (20) tick();
    rv0 = 2'b10;
    n = 0;
    while (!rsv0 && n < 200) begin
      tick(); n++;
      if (rr0 != 2'b00) chk("mid.early_ready", rr0, 2'b00);
    end
    chk("mid.rsp_id", rid0, 3'd0);
    k = 0;
    while (rr0 == 2'b00 && k < 50) begin tick(); k++; end
    chk("mid.ready1_delay", k, 6);
    chk("mid.ready1", rr0, 2'b10);
    rv0 = '0;
    n = 0;
    while (!rsv0 && n < 200) begin tick(); n++; end
    chk("mid.rsp_id1", rid0, 3'd1);
    wait_idle0("mid.idle");
    tx_log.delete();

    // Stray m_valid while m_ready is low must not count as a byte.
    rv0 = 2'b01; ra0 = {8'h00, 8'h33}; rd0 = {32'h0, 32'h55667788};
    tick();
    chk("stray.ready", rr0, 2'b01);
    rv0 = '0;
    n = 0;
    while (!(mr0 == 1'b0 && byte_n[0] == 2 && busy0) && n < 200) begin tick(); n++; end
    inj[0] = 1'b1;
    tick();
    inj[0] = 1'b0;
    n = 0;
    while (!rsv0 && n < 200) begin tick(); n++; end
    chk("stray.rsp_seen", rsv0, 1'b1);
    chk("stray.rsp_data", rdat0, 32'hA5A4A3A2);
    chk("stray.nbytes", tx_log.size(), 6);
    got = '0;
    for (int i = 0; i < 6; i++)
      if (tx_log.size() != 0) got = {got[39:0], tx_log.pop_front()};
    chk("stray.bytes", got, 48'h5A3388776655);
    wait_idle0("stray.idle");
    tx_log.delete();

    // Reset during byte 3 aborts the frame silently.
    rv0 = 2'b10; ra0 = {8'h44, 8'h00}; rd0 = {32'hCAFEF00D, 32'h0};
    tick();
    chk("abort.ready", rr0, 2'b10);
    rv0 = '0;
    n = 0;
    while (!(byte_n[0] == 3 && mr0) && n < 200) begin tick(); n++; end
    rstn = 1'b0;
    tick();
    chk("abort.m_ready", mr0, 1'b0);
    chk("abort.busy", busy0, 1'b0);
    chk("abort.req_ready", rr0, 2'b00);
    rstn = 1'b1;
    saw = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (rsv0) saw = 1; end
    chk("abort.no_rsp", saw, 0);
    tx_log.delete();
    vr = '{2'b01, 8'h5E, 32'h0BADCAFE, 8'h00, 32'h0, 2'b01, 3'd0, 48'h5A5EFECAAD0B};
    run_vec(vr, "after_abort");
    repeat (20) tick();
    chk("hold.rsp_data", rdat0, 32'hA5A4A3A2);
    chk("hold.rsp_id", rid0, 3'd0);

    // No gap: back-to-back frames with a single idle cycle.
    rv1 = 2'b11; ra1 = {8'h21, 8'h12}; rd1 = {32'h89ABCDEF, 32'h01234567};
    n = 0;
    while (rr1 == 2'b00 && n < 100) begin tick(); n++; end
    chk("nogap.first", rr1, 2'b01);
    for (int g = 0; g < 2; g++) begin
      n = 0;
      while (busy1 && n < 200) begin tick(); n++; end
      zeros = 0;
      while (!busy1 && zeros < 20) begin tick(); zeros++; end
      chk($sformatf("nogap.idle%0d", g), zeros, 1);
      chk($sformatf("nogap.grant%0d", g), rr1, (g == 0) ? 2'b10 : 2'b01);
    end
    rv1 = '0;
    chk("nogap.rsp_data", rdat1, 32'hA5A4A3A2);
    n = 0;
    while (busy1 && n < 300) begin tick(); n++; end
    chk("nogap.idle", busy1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
